data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//  Memory-controller end of the MEM-stage data interface. Accepts one read or write per
//  request from the MEM unit and runs it against a multi-cycle backing memory via a
//  req/ack handshake. Holds cpu_stall high until the access finishes, then returns read data.
//  Sits between the MEM unit and the data SRAM/bus.
// PARAMETERS
//  MEM_AW    16   word-address width on the memory side (mem_addr = cpu_addr[MEM_AW+1:2])
//  TIMEOUT   64   max cycles waiting for mem_ack before abort; counter width = $clog2(TIMEOUT+1)
//  ERR_DATA  32'hDEAD_BEEF   read data returned on abort or misaligned access
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous reset, active high
//  cpu_addr     in   32      byte address from MEM unit; held stable while cpu_stall=1
//  cpu_re       in   1       read request
//  cpu_we       in   1       write request (wins if cpu_re also set)
//  cpu_wr_data  in   32      write data; held stable while cpu_stall=1
//  cpu_rd_data  out  32      read data; registered; valid in DONE cycle; held until next read
//  cpu_stall    out  1       freeze pipeline; combinational
//  cpu_err      out  1       one-cycle pulse in DONE if access aborted or misaligned
//  mem_addr     out  MEM_AW  word address to memory; registered
//  mem_req      out  1       request to memory; held until mem_ack
//  mem_wr       out  1       1=write, 0=read; valid with mem_req
//  mem_wr_data  out  32      write data to memory; registered
//  mem_rd_data  in   32      read data from memory; sampled when mem_ack=1
//  mem_ack      in   1       one-cycle completion from memory
// BEHAVIOUR
//  Reset: state=IDLE; cpu_rd_data=0, cpu_err=0, mem_req=0, mem_wr=0, mem_addr=0,
//   mem_wr_data=0, timeout counter=0. Reset mid-access drops mem_req next edge; late ack ignored.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//  IDLE: req = cpu_re|cpu_we. If req and cpu_addr[1:0]==0: latch addr/data/dir, assert
//   mem_req at next edge, go BUSY. If req and misaligned: no memory access, set err, go DONE.
//   No req: stay IDLE.
//  BUSY: mem_req=1. mem_ack=1 -> capture mem_rd_data into cpu_rd_data (reads only),
//   drop mem_req, go DONE. Counter++ each BUSY cycle; if counter reaches TIMEOUT without ack:
//   drop mem_req, cpu_rd_data=ERR_DATA for reads, set err, go DONE.
//  DONE: exactly one cycle; cpu_stall=0, cpu_err valid; request still on inputs is the one
//   just served and is NOT relaunched; go IDLE.
//  cpu_stall = (IDLE & req) | BUSY. Min latency: request cycle + 1 BUSY + DONE = 3 cycles.
//  Misaligned write: memory untouched. Misaligned read: cpu_rd_data=ERR_DATA.
//  mem_ack outside BUSY ignored. Write does not modify cpu_rd_data.
// CONFIGURATION
//  DMEMCTRL_READ_BYPASS_EN defined: one-entry buffer (valid, word address, data) filled on
//   each successful read. IDLE read hitting valid entry -> no memory access, no stall;
//   cpu_rd_data=buffered data at next edge. Any write to the same word updates the buffer
//   with cpu_wr_data. Reset, abort, or error clears valid.
//  Not defined: every read goes to memory; no buffer logic.
// TESTING
//  Read @0x100, mem_ack after 3 BUSY cycles, mem_rd_data=0x12345678 -> mem_addr=0x40,
//   stall 4 cycles, cpu_rd_data=0x12345678 in DONE, cpu_err=0.
//  Write @0x200 data 0xCAFEF00D, ack after 1 -> mem_wr=1, mem_wr_data=0xCAFEF00D,
//   cpu_rd_data unchanged.
//  cpu_re=cpu_we=1 @0x8 -> write performed, no read.
//  Read @0x102 -> no mem_req, DONE next cycle, cpu_err=1, cpu_rd_data=0xDEADBEEF.
//  Read, ack withheld -> mem_req drops after TIMEOUT BUSY cycles, cpu_err=1,
//   cpu_rd_data=0xDEADBEEF; later stray ack ignored.
//  rst during BUSY -> mem_req=0 next edge, state IDLE, all outputs at reset values.
//  BYPASS_EN: read 0x100 twice -> second read no mem_req, no stall; write 0x100 then read
//   -> returns written data with no mem_req.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-side memory controller: one CPU access per request against a req/ack backing memory.
// Optional one-entry read bypass buffer is enabled by defining DMEMCTRL_READ_BYPASS_EN.
module data_mem_ctrl #(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cpu_addr,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_wr_data,
    output logic [31:0]       cpu_rd_data,
    output logic              cpu_stall,
    output logic              cpu_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_ack
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [CNT_W-1:0]  waitCnt;
    logic              cpuReq;
    logic              aligned;
    logic [MEM_AW-1:0] wordAddr;
    logic              launch;
    logic              misalign;
    logic              ackDone;
    logic              abort;
    logic              bypassHit;
    logic [31:0]       bypassData;
    logic              unusedAddrBits;

    assign cpuReq         = cpu_re | cpu_we;
    assign aligned        = (cpu_addr[1:0] == 2'b00);
    assign wordAddr       = cpu_addr[MEM_AW+1:2];
    assign unusedAddrBits = ^cpu_addr[31:MEM_AW+2];

`ifdef DMEMCTRL_READ_BYPASS_EN
    logic              bufValid;
    logic [MEM_AW-1:0] bufAddr;
    logic [31:0]       bufData;

    // A plain aligned read of the buffered word is served without touching memory.
    assign bypassHit  = (state == IDLE) && cpu_re && !cpu_we && aligned
                        && bufValid && (bufAddr == wordAddr);
    assign bypassData = bufData;

    // Buffer tracks the last successful read; writes to that word keep it coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            bufValid <= 1'b0;
            bufAddr  <= '0;
            bufData  <= '0;
        end else if (misalign || abort) begin
            bufValid <= 1'b0;
        end else if (ackDone && !mem_wr) begin
            bufValid <= 1'b1;
            bufAddr  <= mem_addr;
            bufData  <= mem_rd_data;
        end else if (ackDone && mem_wr && bufValid && (bufAddr == mem_addr)) begin
            bufData  <= mem_wr_data;
        end
    end
`else
    assign bypassHit  = 1'b0;
    assign bypassData = '0;
`endif

    assign cpu_stall = ((state == IDLE) && cpuReq && !bypassHit) || (state == BUSY);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode; an ack on the final wait cycle still counts as success.
    always_comb begin
        stateNext = state;
        launch    = 1'b0;
        misalign  = 1'b0;
        ackDone   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (cpuReq && !bypassHit) begin
                    if (aligned) begin
                        launch    = 1'b1;
                        stateNext = BUSY;
                    end else begin
                        misalign  = 1'b1;
                        stateNext = DONE;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    ackDone   = 1'b1;
                    stateNext = DONE;
                end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Memory-side request, wait counter and CPU-side result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt     <= '0;
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cpu_rd_data <= '0;
            cpu_err     <= 1'b0;
        end else begin
            cpu_err <= misalign | abort;

            if (state == BUSY) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end else begin
                waitCnt <= '0;
            end

            if (launch) begin
                mem_req     <= 1'b1;
                mem_wr      <= cpu_we;
                mem_addr    <= wordAddr;
                mem_wr_data <= cpu_wr_data;
            end else if (ackDone || abort) begin
                mem_req <= 1'b0;
                mem_wr  <= 1'b0;
            end

            if (misalign && !cpu_we) begin
                cpu_rd_data <= ERR_DATA;
            end else if (ackDone && !mem_wr) begin
                cpu_rd_data <= mem_rd_data;
            end else if (abort && !mem_wr) begin
                cpu_rd_data <= ERR_DATA;
            end else if (bypassHit) begin
                cpu_rd_data <= bypassData;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed vector table, reset/stray-ack sequences,
// then random accesses checked against a word-array reference model.
module tb_data_mem_ctrl;

    localparam int unsigned TO   = 64;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic        cpu_re = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_wr_data = '0;
    logic [31:0] cpu_rd_data;
    logic        cpu_stall;
    logic        cpu_err;
    logic [15:0] mem_addr;
    logic        mem_req;
    logic        mem_wr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] memArr [0:65535];
    logic [31:0] refMem [0:65535];
    logic [31:0] expRdHold;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ackAt;
        logic [31:0] memData;
        logic [31:0] expRd;
        logic        expErr;
        int          expStall;
        int          expBusy;
        logic [15:0] expMemAddr;
    } vecT;

    vecT vecs [8];

    data_mem_ctrl #(.MEM_AW(16), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one access starting just after a posedge, plays the memory, checks the result.
    task automatic runAccess(input logic re, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ackAt, input logic [31:0] memData,
                             input logic [31:0] expRd, input logic expErr, input int expStall,
                             input int expBusy, input logic [15:0] expMemAddr, input string name);
        int stallCnt = 0;
        int busyCnt  = 0;
        bit finished = 0;
        cpu_re      = re;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_wr_data = wdata;
        for (int cyc = 0; cyc < int'(TO) + 10 && !finished; cyc++) begin
            @(negedge clk);
            if (mem_req) begin
                busyCnt++;
                if (busyCnt == 1) begin
                    check({name, " mem_addr"}, 32'(mem_addr), 32'(expMemAddr));
                    check({name, " mem_wr"}, 32'(mem_wr), 32'(we));
                    if (we) check({name, " mem_wr_data"}, mem_wr_data, wdata);
                end
                if (busyCnt == ackAt) begin
                    mem_ack     = 1'b1;
                    mem_rd_data = memData;
                    if (mem_wr) memArr[mem_addr] = mem_wr_data;
                end
            end
            if (!cpu_stall) begin
                finished = 1;
                check({name, " rd_data"}, cpu_rd_data, expRd);
                check({name, " err"}, 32'(cpu_err), 32'(expErr));
                check({name, " stall_cycles"}, 32'(stallCnt), 32'(expStall));
                check({name, " busy_cycles"}, 32'(busyCnt), 32'(expBusy));
                check({name, " done_req"}, 32'(mem_req), 32'h0);
            end else begin
                stallCnt++;
            end
            @(posedge clk);
            #1 mem_ack = 1'b0;
        end
        if (!finished) check({name, " completion_timeout"}, 32'(stallCnt), 32'(expStall));
        cpu_re = 1'b0;
        cpu_we = 1'b0;
        @(negedge clk);
        check({name, " err_pulse"}, 32'(cpu_err), 32'h0);
        check({name, " no_relaunch"}, 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            memArr[i] = $urandom;
            refMem[i] = memArr[i];
        end

        vecs[0] = '{1'b1, 1'b0, 32'h100,  32'h0,         3,  32'h1234_5678, 32'h1234_5678, 1'b0, 4,  3,  16'h0040};
        vecs[1] = '{1'b0, 1'b1, 32'h200,  32'hCAFE_F00D, 1,  32'h0,         32'h1234_5678, 1'b0, 2,  1,  16'h0080};
        vecs[2] = '{1'b1, 1'b1, 32'h8,    32'h0000_55AA, 2,  32'h0,         32'h1234_5678, 1'b0, 3,  2,  16'h0002};
        vecs[3] = '{1'b1, 1'b0, 32'h102,  32'h0,         1,  32'h0,         ERRD,          1'b1, 1,  0,  16'h0000};
        vecs[4] = '{1'b0, 1'b1, 32'h103,  32'hFFFF_0000, 1,  32'h0,         ERRD,          1'b1, 1,  0,  16'h0000};
        vecs[5] = '{1'b1, 1'b0, 32'h4,    32'h0,         1,  32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 2,  1,  16'h0001};
        vecs[6] = '{1'b1, 1'b0, 32'h8,    32'h0,         0,  32'h0,         ERRD,          1'b1, 65, 64, 16'h0002};
        vecs[7] = '{1'b1, 1'b0, 32'hFFFC, 32'h0,         64, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 65, 64, 16'h3FFF};

        // Reset values while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rd_data", cpu_rd_data, 32'h0);
        check("reset err", 32'(cpu_err), 32'h0);
        check("reset stall", 32'(cpu_stall), 32'h0);
        check("reset mem_req", 32'(mem_req), 32'h0);
        check("reset mem_wr", 32'(mem_wr), 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset mem_wr_data", mem_wr_data, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            runAccess(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ackAt,
                      vecs[i].memData, vecs[i].expRd, vecs[i].expErr, vecs[i].expStall,
                      vecs[i].expBusy, vecs[i].expMemAddr, $sformatf("vec%0d", i));
            if (vecs[i].we && vecs[i].addr[1:0] == 2'b00 && vecs[i].ackAt != 0)
                refMem[vecs[i].addr[17:2]] = vecs[i].wdata;
        end

        // Stray ack while idle is ignored.
        mem_ack = 1'b1;
        mem_rd_data = 32'h1111_1111;
        @(negedge clk);
        check("stray_ack stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("stray_ack rd_data", cpu_rd_data, 32'h0BAD_F00D);
        check("stray_ack mem_req", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;

        // Reset in the middle of a BUSY access.
        cpu_re = 1'b1;
        cpu_addr = 32'h40;
        @(negedge clk);
        check("rst_busy stall_req", 32'(cpu_stall), 32'h1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy mem_req_up", 32'(mem_req), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        cpu_re = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy mem_req", 32'(mem_req), 32'h0);
        check("rst_busy stall", 32'(cpu_stall), 32'h0);
        check("rst_busy rd_data", cpu_rd_data, 32'h0);
        check("rst_busy err", 32'(cpu_err), 32'h0);
        check("rst_busy mem_addr", 32'(mem_addr), 32'h0);
        check("rst_busy mem_wr", 32'(mem_wr), 32'h0);
        mem_ack = 1'b1;
        mem_rd_data = 32'h7777_7777;
        @(posedge clk);
        #1 mem_ack = 1'b0;
        @(negedge clk);
        check("late_ack rd_data", cpu_rd_data, 32'h0);
        check("late_ack stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1;
        expRdHold = 32'h0;

`ifdef DMEMCTRL_READ_BYPASS_EN
        runAccess(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h1111_2222, 32'h1111_2222, 1'b0, 2, 1, 16'h0040, "byp_fill");
        cpu_re = 1'b1;
        cpu_addr = 32'h100;
        @(negedge clk);
        check("byp_hit stall", 32'(cpu_stall), 32'h0);
        check("byp_hit mem_req", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1 cpu_re = 1'b0;
        @(negedge clk);
        check("byp_hit rd_data", cpu_rd_data, 32'h1111_2222);
        check("byp_hit no_req", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;
        runAccess(1'b0, 1'b1, 32'h100, 32'h3333_4444, 1, 32'h0, 32'h1111_2222, 1'b0, 2, 1, 16'h0040, "byp_wr");
        cpu_re = 1'b1;
        cpu_addr = 32'h100;
        @(negedge clk);
        check("byp_wr_hit stall", 32'(cpu_stall), 32'h0);
        @(posedge clk);
        #1 cpu_re = 1'b0;
        @(negedge clk);
        check("byp_wr_hit rd_data", cpu_rd_data, 32'h3333_4444);
        check("byp_wr_hit no_req", 32'(mem_req), 32'h0);
        @(posedge clk);
        #1;
`else
        // Random accesses against a word-array model of the memory.
        for (int n = 0; n < 150; n++) begin
            int unsigned word;
            int unsigned off;
            int unsigned sel;
            int          ackAt;
            logic        re;
            logic        we;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic        expErr;
            int          expStall;
            int          expBusy;
            word  = $urandom_range(0, 63);
            off   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            sel   = $urandom_range(0, 2);
            re    = (sel != 1);
            we    = (sel != 0);
            ackAt = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6));
            addr  = (32'(word) << 2) | 32'(off);
            wdata = $urandom;
            if (off != 0) begin
                expErr = 1'b1; expStall = 1; expBusy = 0;
                if (!we) expRdHold = ERRD;
            end else if (ackAt == 0) begin
                expErr = 1'b1; expStall = 1 + int'(TO); expBusy = int'(TO);
                if (!we) expRdHold = ERRD;
            end else begin
                expErr = 1'b0; expStall = 1 + ackAt; expBusy = ackAt;
                if (we) refMem[word] = wdata;
                else    expRdHold = refMem[word];
            end
            runAccess(re, we, addr, wdata, ackAt, memArr[word], expRdHold, expErr,
                      expStall, expBusy, 16'(word), $sformatf("rnd%0d", n));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
